// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width_src encodings, FSM
// state type and small decode helpers used by the top and load_extend.
package load_store_unit_pkg;

    localparam logic [2:0] WIDTH_WORD   = 3'b000;
    localparam logic [2:0] WIDTH_BYTE   = 3'b001;
    localparam logic [2:0] WIDTH_HALF   = 3'b010;
    localparam logic [2:0] WIDTH_BYTE_U = 3'b101;
    localparam logic [2:0] WIDTH_HALF_U = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } lsu_size_t;

    // Unlisted encodings fall back to a full word access.
    function automatic lsu_size_t decode_size(input logic [2:0] w);
        case (w)
            WIDTH_BYTE, WIDTH_BYTE_U: return SZ_BYTE;
            WIDTH_HALF, WIDTH_HALF_U: return SZ_HALF;
            default:                  return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned(input logic [2:0] w);
        return (w == WIDTH_BYTE_U) || (w == WIDTH_HALF_U);
    endfunction

    function automatic logic [3:0] lane_be(input lsu_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the source so every enabled byte lane sees the right data.
    function automatic logic [31:0] lane_wdata(input lsu_size_t sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane from a read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  width_src,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        zext;

    // Lane select by low address bits, then extend according to width.
    always_comb begin
        byte_lane = rdata[7:0];
        half_lane = rdata[15:0];
        zext      = is_unsigned(width_src);
        case (addr)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        if (addr[1]) begin
            half_lane = rdata[31:16];
        end
        case (decode_size(width_src))
            SZ_BYTE: result = {{24{byte_lane[7] & ~zext}}, byte_lane};
            SZ_HALF: result = {{16{half_lane[15] & ~zext}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op, drives a single-beat bus
// request with byte enables and replicated write data, and returns the
// extended load result. Optional MISALIGN_CHECK_EN traps misaligned
// half/word accesses without touching the bus.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_op_valid,
    input  logic        mem_write,
    input  logic [2:0]  width_src,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        op_done,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    lsu_state_t  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  width_q, width_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        op_done_q, op_done_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] load_data_q, load_data_d;

    lsu_size_t   in_size;
    logic        mis_hit;
    logic [31:0] ext_result;

    assign in_size = decode_size(width_src);

`ifdef MISALIGN_CHECK_EN
    assign mis_hit = is_misaligned(in_size, addr[1:0]);
`else
    assign mis_hit = 1'b0;
`endif

    // Extraction uses the latched width/offset, not the live pipeline inputs.
    load_extend u_load_extend (
        .rdata     (bus_rdata),
        .addr      (addr_lo_q),
        .width_src (width_q),
        .result    (ext_result)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        width_d      = width_q;
        addr_lo_d    = addr_lo_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        op_done_d    = 1'b0;
        misaligned_d = 1'b0;
        load_data_d  = load_data_q;
        case (state_q)
            IDLE: begin
                if (mem_op_valid) begin
                    write_d     = mem_write;
                    width_d     = width_src;
                    addr_lo_d   = addr[1:0];
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = lane_be(in_size, addr[1:0]);
                    bus_wdata_d = lane_wdata(in_size, store_data);
                    if (mis_hit) begin
                        state_d      = DONE;
                        op_done_d    = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = REQ;
                        bus_req_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (write_q) begin
                        state_d   = DONE;
                        op_done_d = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    load_data_d = ext_result;
                    state_d     = DONE;
                    op_done_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            width_q      <= WIDTH_WORD;
            addr_lo_q    <= 2'b00;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= '0;
            op_done_q    <= 1'b0;
            misaligned_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            width_q      <= width_d;
            addr_lo_q    <= addr_lo_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            op_done_q    <= op_done_d;
            misaligned_q <= misaligned_d;
            load_data_q  <= load_data_d;
        end
    end

    assign stall      = ((state_q == IDLE) && mem_op_valid) ||
                        (state_q == REQ) || (state_q == WAIT_R);
    assign load_data  = load_data_q;
    assign op_done    = op_done_q;
    assign misaligned = misaligned_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Ports SHALL be:
- clk, input, 1: clock
- reset, input, 1: synchronous active-high reset
- mem_op_valid, input, 1: memory instruction present in the stage
- mem_write, input, 1: 1 = store, 0 = load
- width_src, input, 3: access width from the width decoder
- addr, input, 32: byte address
- store_data, input, 32: unaligned store source
- load_data, output, 32: extended load result
- op_done, output, 1: one-cycle completion pulse
- stall, output, 1: hold the upstream pipeline
- misaligned, output, 1: misaligned access flag
- bus_req, output, 1; bus_we, output, 1; bus_addr, output, 32; bus_be, output, 4; bus_wdata, output, 32: memory request
- bus_gnt, input, 1; bus_rvalid, input, 1; bus_rdata, input, 32: memory response

Function
REQ-003 width_src encodings SHALL be: 000 word; 001 byte signed; 010 half signed; 101 byte unsigned; 110 half unsigned; any other value SHALL be treated as word.
REQ-004 The FSM SHALL have the states IDLE, REQ, WAIT_R and DONE.
REQ-005 In IDLE with mem_op_valid=1, the block SHALL latch mem_write, width_src, addr and store_data, then go to REQ on the next cycle.
REQ-006 In REQ, bus_req SHALL be 1, and bus_addr, bus_we, bus_be and bus_wdata SHALL be stable from the latched values until bus_gnt=1.
REQ-007 On bus_gnt in REQ, a store SHALL go to DONE and a load SHALL go to WAIT_R.
REQ-008 bus_rvalid SHALL arrive no earlier than the cycle after bus_gnt; bus_rvalid SHALL be ignored in every state except WAIT_R.
REQ-009 In WAIT_R with bus_rvalid=1, the block SHALL register the extended bus_rdata into load_data and go to DONE.
REQ-010 In DONE, op_done SHALL be 1 for exactly one cycle, stall SHALL be 0, and the next state SHALL be IDLE; no new operation SHALL be accepted in DONE.
REQ-011 stall SHALL equal (IDLE and mem_op_valid) or REQ or WAIT_R; it SHALL be combinational.
REQ-012 bus_addr SHALL be {addr[31:2], 2'b00}.
REQ-013 bus_be SHALL be: word 1111; half 0011 when addr[1]=0, else 1100; byte 0001 shifted left by addr[1:0].
REQ-014 bus_wdata SHALL be: word unchanged; half {2{store_data[15:0]}}; byte {4{store_data[7:0]}}.
REQ-015 Load extraction SHALL select the byte or half lane indicated by addr[1:0]; signed widths SHALL sign-extend and unsigned widths SHALL zero-extend to 32 bits.
REQ-016 load_data SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-017 Minimum latency SHALL be: store 3 cycles from acceptance to op_done (gnt in the first REQ cycle); load 4 cycles (rvalid the cycle after gnt).

Reset
REQ-018 On reset, the state SHALL be IDLE, and load_data, op_done, misaligned, bus_req and bus_we SHALL be 0; bus_be SHALL be 0000.
REQ-019 Reset in any state, including mid-transaction, SHALL drop bus_req at that edge; any later bus_rvalid SHALL be ignored in IDLE.

Configuration
REQ-020 With MISALIGN_CHECK_EN defined, a half with addr[0]=1 or a word with addr[1:0]!=00 SHALL skip the bus (bus_req stays 0) and go from IDLE to DONE on the next cycle, with misaligned=1 and op_done=1 in DONE, and load_data unchanged.
REQ-021 Without MISALIGN_CHECK_EN, misaligned SHALL be tied to 0, and the access SHALL proceed using the bus_be rules of REQ-013 (word 1111, half selected by addr[1]).

Structure
REQ-022 A shared package SHALL hold the width_src encoding constants (WIDTH_WORD, WIDTH_BYTE, WIDTH_HALF, WIDTH_BYTE_U, WIDTH_HALF_U) and the FSM enum lsu_state_t.
REQ-023 The lane select and extension SHALL be a combinational sub-module named load_extend (inputs: rdata, addr[1:0], width_src; output: 32-bit result).

Verification
REQ-024 The bench SHALL cover these scenarios:
- Load byte signed (001), addr=0x1003, bus_rdata=0x80FF_1234, gnt and rvalid with no wait -> bus_be=1000, load_data=0xFFFF_FF80, op_done 4 cycles after acceptance.
- Load half unsigned (110), addr=0x2002, bus_rdata=0xBEEF_0000 -> bus_be=1100, load_data=0x0000_BEEF.
- Store half (010), addr=0x3002, store_data=0x1234_ABCD, gnt held low for 3 cycles -> bus_req held for 4 cycles, bus_wdata=0xABCD_ABCD, bus_be=1100, stall stays high until DONE.
- Store word, addr=0x4000, data=0xDEAD_BEEF -> bus_be=1111; load_data unchanged.
- Reset asserted in WAIT_R, then bus_rvalid=1 -> state IDLE, op_done never pulses, load_data=0.
- MISALIGN_CHECK_EN defined, load word at addr=0x5001 -> bus_req never asserted, misaligned=1 and op_done=1 on the second cycle; without the macro, misaligned=0 and bus_be=1111.
